// File: rtl/load_reg_pkg.sv
// Shared constants for the UART RX receive-data register block.
package load_reg_pkg;

    // Received word: [7:0] data byte, [8] framing-error flag.
    localparam int RX_W = 9;

    // Register addresses on the read-only slave port.
    localparam logic [1:0] ADDR_RXDATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_CLRFLAGS = 2'd2;
    localparam logic [1:0] ADDR_ID       = 2'd3;

    // STATUS register bit positions.
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME     = 3;
    localparam int ST_COUNT_LSB = 8;

    // RXDATA register: valid bit marking that a word was popped.
    localparam int RXD_VALID    = 31;

endpackage

// File: rtl/load_reg_rx_fifo.sv
// Small circular FIFO holding received UART words (DEPTH must be a power of two, >= 2).
module rx_fifo
    import load_reg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [RX_W-1:0] wdata,
    output logic [RX_W-1:0] head,
    output logic [AW:0]     count,
    output logic            empty,
    output logic            full,
    output logic            push_ok
);

    logic [RX_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    // A pop on an empty FIFO is a no-op; a pop frees a slot for a same-cycle push when full.
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/load_reg.sv
// Receive-data register block: captures UART RX words into a FIFO and exposes
// data, status, sticky error flags and an ID through a read-only slave port.
module load_reg
    import load_reg_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] ID_VALUE = 32'h5258_0001
) (
    input  logic            clk,
    input  logic            reset_n,   // active-high despite the name
    input  logic [1:0]      address,
    input  logic            read,
    input  logic            chipselect,
    input  logic [RX_W-1:0] RX_data,
    input  logic            load,
    output logic [31:0]     readdata
);

    localparam int AW = $clog2(DEPTH);

    logic            read_q;
    logic            access;
    logic            pop;
    logic            clr;
    logic            push_ok;
    logic            overrun;
    logic            frame_err;
    logic            set_overrun;
    logic            set_frame;
    logic [RX_W-1:0] head;
    logic [AW:0]     count;
    logic            empty;
    logic            full;
    logic [31:0]     status;

    // Only the first cycle of a held read is an access.
    assign access = chipselect & read & ~read_q;
    assign pop    = access & (address == ADDR_RXDATA);
    assign clr    = access & (address == ADDR_CLRFLAGS);

    rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rst     (reset_n),
        .push    (load),
        .pop     (pop),
        .wdata   (RX_data),
        .head    (head),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .push_ok (push_ok)
    );

    assign set_overrun = load & ~push_ok;
    assign set_frame   = push_ok & RX_data[RX_W-1];

    // Assemble the STATUS word from live FIFO state and sticky flags.
    always_comb begin
        status                       = '0;
        status[ST_NOT_EMPTY]         = ~empty;
        status[ST_FULL]              = full;
        status[ST_OVERRUN]           = overrun;
        status[ST_FRAME]             = frame_err;
        status[ST_COUNT_LSB +: 8]    = 8'(count);
    end

    // Read edge detect.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) read_q <= 1'b0;
        else         read_q <= chipselect & read;
    end

    // Sticky flags: a same-cycle set overrides a clear.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun   & ~clr) | set_overrun;
            frame_err <= (frame_err & ~clr) | set_frame;
        end
    end

    // Registered read data, loaded only on an access and held otherwise.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            readdata <= '0;
        end else if (access) begin
            unique case (address)
                ADDR_RXDATA: begin
                    readdata <= '0;
                    if (!empty) begin
                        readdata[RXD_VALID]  <= 1'b1;
                        readdata[RX_W-1:0]   <= head;
                    end
                end
                ADDR_STATUS:   readdata <= status;
                ADDR_CLRFLAGS: readdata <= {30'b0, frame_err, overrun};
                ADDR_ID:       readdata <= ID_VALUE;
                default:       readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_reg.sv
// Self-checking bench for load_reg: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_load_reg;

    localparam int          DEPTH = 4;
    localparam logic [31:0] ID    = 32'h5258_0001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        chipselect = 1'b0;
    logic [8:0]  RX_data = '0;
    logic        load = 1'b0;
    logic [31:0] readdata;

    load_reg #(.DEPTH(DEPTH), .ID_VALUE(ID)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .read       (read),
        .chipselect (chipselect),
        .RX_data    (RX_data),
        .load       (load),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [8:0]  q[$];
    logic        m_ov, m_fe, m_prev;
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_fe = 0; m_prev = 0; m_rd = 0;
    endtask

    // One clock edge of the specified behaviour, from current inputs.
    task automatic model_step();
        logic acc;
        acc = chipselect & read & ~m_prev;
        m_prev = chipselect & read;
        if (acc) begin
            case (address)
                2'd0: if (q.size() > 0) m_rd = 32'h8000_0000 | 32'(q.pop_front());
                      else              m_rd = 0;
                2'd1: m_rd = {16'h0, 8'(q.size()), 4'h0, m_fe, m_ov,
                              q.size() == DEPTH, q.size() != 0};
                2'd2: begin m_rd = {30'h0, m_fe, m_ov}; m_ov = 0; m_fe = 0; end
                default: m_rd = ID;
            endcase
        end
        if (load) begin
            if (q.size() < DEPTH) begin
                q.push_back(RX_data);
                if (RX_data[8]) m_fe = 1;
            end else begin
                m_ov = 1;
            end
        end
    endtask

    task automatic cyc(input logic ld, input logic [8:0] d, input logic cs,
                       input logic rd, input logic [1:0] a);
        load = ld; RX_data = d; chipselect = cs; read = rd; address = a;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model", readdata, m_rd);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
        cyc(0, 0, 1, 1, a);
        v = readdata;
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("async_reset", readdata, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 0;
    endtask

    logic [31:0] v;

    initial begin
        model_reset();
        do_reset();
        chk("reset_readdata", readdata, 32'h0);
        rd_reg(1, v); chk("reset_status", v, 32'h0);
        rd_reg(3, v); chk("id", v, ID);

        // Single load, read held two cycles: one access, one pop.
        cyc(1, 9'h054, 0, 0, 0);
        cyc(0, 0, 1, 1, 0); chk("single_rx", readdata, 32'h8000_0054);
        cyc(0, 0, 1, 1, 0); chk("single_hold", readdata, 32'h8000_0054);
        cyc(0, 0, 0, 0, 0);
        rd_reg(1, v); chk("single_status", v, 32'h0);

        // Back-to-back loads.
        cyc(1, 9'h054, 0, 0, 0);
        cyc(1, 9'h02C, 0, 0, 0);
        rd_reg(1, v); chk("b2b_count", v, 32'h0000_0201);
        rd_reg(0, v); chk("b2b_rx0", v, 32'h8000_0054);
        rd_reg(0, v); chk("b2b_rx1", v, 32'h8000_002C);
        rd_reg(0, v); chk("b2b_empty", v, 32'h0);

        // Overrun.
        for (int i = 1; i <= 5; i++) cyc(1, 9'(i), 0, 0, 0);
        rd_reg(1, v); chk("ovr_status", v, 32'h0000_0407);
        for (int i = 1; i <= 4; i++) begin
            rd_reg(0, v); chk("ovr_rx", v, 32'h8000_0000 | 32'(i));
        end
        rd_reg(2, v); chk("ovr_clr", v, 32'h1);
        rd_reg(1, v); chk("ovr_cleared", v, 32'h0);

        // Frame error.
        cyc(1, 9'h1AA, 0, 0, 0);
        rd_reg(0, v); chk("fe_rx", v, 32'h8000_01AA);
        rd_reg(1, v); chk("fe_status", v, 32'h8);
        rd_reg(2, v); chk("fe_clr", v, 32'h2);
        rd_reg(1, v); chk("fe_cleared", v, 32'h0);

        // Load and pop together while full: no overrun, order kept.
        for (int i = 0; i < 4; i++) cyc(1, 9'(8'h10 + i), 0, 0, 0);
        cyc(1, 9'h014, 1, 1, 0); chk("full_pop", readdata, 32'h8000_0010);
        cyc(0, 0, 0, 0, 0);
        rd_reg(1, v); chk("full_pop_status", v, 32'h0000_0403);
        for (int i = 1; i <= 4; i++) begin
            rd_reg(0, v); chk("full_pop_order", v, 32'h8000_0010 + 32'(i));
        end

        // Load and pop while empty: pop sees empty, load is kept.
        cyc(1, 9'h033, 1, 1, 0); chk("empty_pop", readdata, 32'h0);
        cyc(0, 0, 0, 0, 0);
        // chipselect low: no pop, readdata holds.
        cyc(0, 0, 0, 1, 0); chk("cs_low_hold", readdata, 32'h0);
        cyc(0, 0, 0, 0, 0);
        rd_reg(1, v); chk("cs_low_status", v, 32'h0000_0101);

        // Flag set and CLRFLAGS same cycle: set wins.
        for (int i = 0; i < 4; i++) cyc(1, 9'h001, 0, 0, 0);
        cyc(1, 9'h1FF, 1, 1, 2); chk("clr_vs_set", readdata, 32'h1);
        cyc(0, 0, 0, 0, 0);
        rd_reg(1, v); chk("set_wins", v, 32'h0000_0407);

        // Randomized traffic with one mid-run reset while read is held.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                chipselect = 1; read = 1; address = 2'd1;
                do_reset();
            end
            cyc(($urandom_range(0, 2) == 0), 9'($urandom_range(0, 511)),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1),
                2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_reg.md
Name: load_reg

Overview:
- Memory-mapped receive-data register block for the custom UART RX IP.
- Captures each 9-bit word the UART receiver core presents on a `load` strobe into a small FIFO.
- Exposes data, status and sticky error flags to the processor through a 2-bit-address, read-only slave port with a 32-bit data bus.
- Sits between the UART RX shift/timing logic and the system interconnect.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- ID_VALUE, 32'h5258_0001, constant returned at address 3.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-high reset. Asserted when high, despite the suffix. Clears all state immediately.
- address  input  2  register select for slave reads.
- read  input  1  read strobe. May be held for multiple cycles.
- chipselect  input  1  slave select; read is ignored unless chipselect=1.
- RX_data  input  9  [7:0] received byte, [8] framing-error flag (bad stop bit) from the UART core.
- load  input  1  single-cycle strobe: RX_data is valid and must be captured.
- readdata  output  32  registered read data.

Behaviour:
- Reset (reset_n=1, async):
  - FIFO empty, pointers and count = 0.
  - Sticky overrun and frame-error flags = 0.
  - readdata = 0.
  - Edge-detect register read_q = 0.
- Read access:
  - An access starts on a cycle where chipselect & read & !read_q. read_q is the registered value of (chipselect & read).
  - Only the first cycle of a multi-cycle read is an access. Holding read for N cycles performs exactly one access.
  - readdata is loaded at the clock edge ending the first cycle, giving one-cycle latency. It holds its value until the next access or reset.
  - read with chipselect=0 has no effect.
- Address map (readdata bits not listed are 0):
  - addr 0, RXDATA:
    - [8:0] = head entry; [31] = 1 if the FIFO was non-empty.
    - If non-empty, pops one entry.
    - If empty, returns 0 (bit31=0) and does not pop.
  - addr 1, STATUS (no side effects):
    - [0] = not-empty; [1] = full; [2] = overrun sticky; [3] = frame-error sticky.
    - [15:8] = current entry count.
  - addr 2, CLRFLAGS: returns [0] = overrun and [1] = frame-error, then clears both flags in the same edge.
  - addr 3, ID: returns ID_VALUE.
- Load:
  - On a rising edge with load=1, RX_data is written at the tail if the FIFO is not full. Count is incremented.
  - The frame-error sticky flag is set if RX_data[8]=1 on an accepted load.
  - load while full (without a simultaneous pop): the word is dropped, FIFO unchanged, overrun sticky set.
- Simultaneous events:
  - load and pop in the same cycle: count unchanged, both pointers advance. When full, the load is accepted with no overrun.
  - load and pop when empty: the pop returns empty (bit31=0) and the load is written.
  - Flag set (load) and CLRFLAGS in the same cycle: the set wins, so the flag reads 1 afterwards.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and saturates by construction (0..DEPTH).
- Reset mid-access or mid-load: all state clears immediately. A read still asserted after reset release counts as a new access only if read_q was 0, i.e. on the first cycle after release.

Decomposition:
- Package load_reg_pkg holds:
  - Address constants ADDR_RXDATA=0, ADDR_STATUS=1, ADDR_CLRFLAGS=2, ADDR_ID=3.
  - Status bit-position constants.
  - Word width constant RX_W=9.
- One natural sub-module: rx_fifo (DEPTH x 9 storage, push/pop, full/empty/count).
- Register decode, edge detect and sticky flags live in the top.

Test Plan:
- Reset: drive reset_n=1 for 2 cycles, release -> readdata=0; STATUS read returns 0.
- Single load: RX_data=9'h054, load pulse, then read addr 0 held 2 cycles -> readdata=32'h8000_0054 one cycle after read rises; exactly one pop; STATUS then reads 0.
- Back-to-back: load 9'h054 then 9'h02C; read addr 1 -> count=2. Read addr 0 twice -> 32'h8000_0054, then 32'h8000_002C. Third read -> 32'h0000_0000.
- Overrun: 5 loads (0x01..0x05) with DEPTH=4 -> STATUS [1]=1, [2]=1, count=4. Reads return 0x01..0x04. CLRFLAGS returns 1 and clears the flag.
- Frame error: load 9'h1AA -> RXDATA reads 32'h8000_01AA; STATUS [3]=1. CLRFLAGS returns 32'h2, then STATUS [3]=0.
- Simultaneous load and pop when full -> no overrun, count stays 4, FIFO order preserved. chipselect=0 with read=1 -> no pop, readdata unchanged.
